serial_adder_ctrl: RTL and testbench

Sequencing controller for the existing bit-serial adder (ports clk, rst, a, b, sum, carry). It accepts two W-bit operands through a valid/ready handshake and clears the adder's carry. It then drives operand bits LSB-first into the adder, collects the serial sum bits into a parallel result with carry-out, and holds the result until the consumer accepts it. The adder is instantiated alongside this block; the controller owns its a, b and rst inputs.

---
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Sequencing controller for a bit-serial adder: accepts two W-bit operands,
// streams them LSB-first into the adder and assembles the serial sum.
module serial_adder_ctrl #(
    parameter int W       = 8,
    parameter int SUM_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         busy,
    output logic         sa_a,
    output logic         sa_b,
    output logic         sa_rst,
    input  logic         sa_sum,
    input  logic         sa_carry
);

    localparam int TOT = W + SUM_LAT;
    localparam int CW  = $clog2(TOT + 1);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    state_t        r_state, w_nxt;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sh_a, r_sh_b, r_acc;
    logic          w_accept, w_last, w_sample;
    logic          w_in_ready, w_out_valid, w_busy, w_sa_rst;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(TOT - 1));
    // The first SUM_LAT cycles of SHIFT only fill the adder's sum pipeline.
    assign w_sample = (r_state == SHIFT) && (int'(r_cnt) >= SUM_LAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nxt = CLR;
            CLR:     w_nxt = SHIFT;
            SHIFT:   if (w_last) w_nxt = DONE;
            DONE:    if (out_ready) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        w_in_ready  = (w_nxt == IDLE);
        w_out_valid = (w_nxt == DONE);
        w_busy      = (w_nxt != IDLE);
        w_sa_rst    = (w_nxt == CLR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sa_rst    <= 1'b1;
        end else begin
            in_ready  <= w_in_ready;
            out_valid <= w_out_valid;
            busy      <= w_busy;
            sa_rst    <= w_sa_rst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            result <= '0;
            cout   <= 1'b0;
            sa_a   <= 1'b0;
            sa_b   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sh_a <= op_a;
                r_sh_b <= op_b;
            end else if (w_nxt == SHIFT) begin
                r_sh_a <= r_sh_a >> 1;
                r_sh_b <= r_sh_b >> 1;
            end
            // Zero fill of the shifters supplies the trailing zero bits.
            sa_a <= (w_nxt == SHIFT) ? r_sh_a[0] : 1'b0;
            sa_b <= (w_nxt == SHIFT) ? r_sh_b[0] : 1'b0;
            if (r_state == CLR)        r_cnt <= '0;
            else if (r_state == SHIFT) r_cnt <= r_cnt + 1'b1;
            if (w_sample) r_acc <= {sa_sum, r_acc[W-1:1]};
            if (w_last) begin
                result <= {sa_sum, r_acc[W-1:1]};
                cout   <= sa_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: two instances (combinational and registered-sum adder)
// checked against plain integer addition.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid, out_ready, sel;
    logic [W-1:0] op_a, op_b;
    int           checks = 0;
    int           errors = 0;

    logic iv0, ir0, ov0, or0, co0, bz0, a0, b0, sr0, s0, cy0, c0;
    logic iv1, ir1, ov1, or1, co1, bz1, a1, b1, sr1, s1, cy1, c1;
    logic [W-1:0] res0, res1;

    assign iv0 = in_valid && !sel;
    assign iv1 = in_valid && sel;
    assign or0 = out_ready && !sel;
    assign or1 = out_ready && sel;

    logic         m_in_ready, m_out_valid, m_cout, m_busy, m_sa_a, m_sa_rst;
    logic [W-1:0] m_result;
    assign m_in_ready  = sel ? ir1  : ir0;
    assign m_out_valid = sel ? ov1  : ov0;
    assign m_cout      = sel ? co1  : co0;
    assign m_busy      = sel ? bz1  : bz0;
    assign m_sa_a      = sel ? a1   : a0;
    assign m_sa_rst    = sel ? sr1  : sr0;
    assign m_result    = sel ? res1 : res0;

    // Serial adder with combinational sum.
    assign s0  = a0 ^ b0 ^ c0;
    assign cy0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
    always @(posedge clk) c0 <= sr0 ? 1'b0 : cy0;

    // Serial adder with registered sum and carry-out.
    always @(posedge clk) begin
        if (sr1) begin
            c1 <= 1'b0; s1 <= 1'b0; cy1 <= 1'b0;
        end else begin
            s1  <= a1 ^ b1 ^ c1;
            cy1 <= (a1 & b1) | (a1 & c1) | (b1 & c1);
            c1  <= (a1 & b1) | (a1 & c1) | (b1 & c1);
        end
    end

    serial_adder_ctrl #(.W(W), .SUM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .op_a(op_a), .op_b(op_b),
        .out_valid(ov0), .out_ready(or0), .result(res0), .cout(co0), .busy(bz0),
        .sa_a(a0), .sa_b(b0), .sa_rst(sr0), .sa_sum(s0), .sa_carry(cy0));

    serial_adder_ctrl #(.W(W), .SUM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op_a(op_a), .op_b(op_b),
        .out_valid(ov1), .out_ready(or1), .result(res1), .cout(co1), .busy(bz1),
        .sa_a(a1), .sa_b(b1), .sa_rst(sr1), .sa_sum(s1), .sa_carry(cy1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_in_ready && n < 50) begin tick(); n++; end
        chk("accept_timeout", 32'(n < 50), 1);
    endtask

    // Launch one operation and check latency, serial bit order, result and carry.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hs);
        logic [W:0]   sum_ref;
        logic [W-1:0] seq;
        int           e;
        sum_ref  = {1'b0, a} + {1'b0, b};
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        e   = 0;
        seq = '0;
        while (!m_out_valid && e < 100) begin
            tick();
            e++;
            if (e >= 1 && e <= W) seq[e-1] = m_sa_a;
        end
        chk("latency", e, W + 1 + int'(sel));
        chk("sa_a_seq", seq, a);
        chk("result", m_result, sum_ref[W-1:0]);
        chk("cout", m_cout, sum_ref[W]);
        if (hs) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("out_valid_drop", m_out_valid, 0);
            chk("busy_idle", m_busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; op_a = '0; op_b = '0;
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", m_in_ready, 0);
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_result", m_result, 0);
        chk("rst_cout", m_cout, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_sa_a", m_sa_a, 0);
        chk("rst_sa_rst", m_sa_rst, 1);
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready", m_in_ready, 1);
        chk("post_rst_sa_rst", m_sa_rst, 0);

        do_op(8'h5A, 8'h3C, 1'b1);
        do_op(8'hFF, 8'h01, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1);
        do_op(8'h00, 8'h00, 1'b1);

        // Backpressure with an ignored in_valid pulse.
        do_op(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin op_a = 8'h77; op_b = 8'h11; in_valid = 1'b1; end
            tick();
            in_valid = 1'b0;
            chk("bp_out_valid", m_out_valid, 1);
            chk("bp_result", m_result, 8'h46);
            chk("bp_cout", m_cout, 0);
            chk("bp_in_ready", m_in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", m_out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_no_capture", m_busy, 0);
        end

        // Reset in the middle of SHIFT.
        op_a = 8'h5A; op_b = 8'h3C; in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", m_out_valid, 0);
        chk("mid_rst_result", m_result, 0);
        chk("mid_rst_sa_rst", m_sa_rst, 1);
        chk("mid_rst_in_ready", m_in_ready, 0);
        chk("mid_rst_busy", m_busy, 0);
        #1 rst = 1'b1;
        tick();
        chk("mid_rst_release", m_in_ready, 1);

        sel = 1'b1;
        do_op(8'hA5, 8'h5A, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1);
        do_op(8'h00, 8'h00, 1'b1);

        // Back-to-back throughput on each instance.
        for (int s = 0; s < 2; s++) begin
            int   prev;
            logic last;
            logic [W:0] tsum;
            sel  = s[0];
            op_a = W'($urandom);
            op_b = W'($urandom);
            tsum = {1'b0, op_a} + {1'b0, op_b};
            prev = -1;
            last = m_out_valid;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            for (int c = 0; c < 60; c++) begin
                tick();
                if (m_out_valid && !last) begin
                    if (prev >= 0) chk("period", c - prev, W + 3 + s);
                    chk("tp_result", {m_cout, m_result}, tsum);
                    prev = c;
                end
                last = m_out_valid;
            end
            in_valid = 1'b0;
            repeat (20) tick();
            out_ready = 1'b0;
            chk("tp_drained", m_busy, 0);
        end

        // Randomized operands, instance and backpressure.
        for (int i = 0; i < 30; i++) begin
            sel = 1'($urandom_range(0, 1));
            do_op(W'($urandom), W'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
            chk("rand_hold", m_out_valid, 1);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("rand_release", m_out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
